// File: rtl/seg7_display_mux_pkg.sv
// rtl/seg7_display_mux_pkg.sv - shared BCD and segment types and segment constants
package packs;

    typedef logic [3:0] BCDnumber_t;

    // Active-low segment pattern {g,f,e,d,c,b,a}
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;
    localparam seg7_t SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low 7-segment decoder
module bcd_to_seg7
    import packs::*;
(
    input  BCDnumber_t  bcd,
    output logic [6:0]  seg
);

    // Digits 0..9 map to standard glyphs; non-BCD codes show a dash
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_display_mux.sv
// rtl/seg7_display_mux.sv - time-multiplexed BCD display driver (optional LEADING_ZERO_BLANK_EN)
module seg7_display_mux
    import packs::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  BCDnumber_t [N_DIGITS-1:0]   digits,
    input  logic                        overflow,
    output logic [N_DIGITS-1:0]         anode,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic                        frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]              cnt;
    logic [IW-1:0]              idx;
    BCDnumber_t [N_DIGITS-1:0]  snap;
    logic                       snap_ovf;

    logic                       strobe;
    logic                       wrap;
    logic [IW-1:0]              idx_next;
    BCDnumber_t [N_DIGITS-1:0]  snap_next;
    logic                       ovf_next;
    BCDnumber_t                 sel_digit;
    logic [6:0]                 dec_seg;

    // The snapshot's next value feeds the decoder so the first digit of a
    // frame is shown from the data captured on that same wrap strobe.
    always_comb begin
        strobe    = (cnt == TERM);
        wrap      = strobe && (idx == LAST);
        idx_next  = idx;
        if (strobe) begin
            idx_next = (idx == LAST) ? '0 : idx + 1'b1;
        end
        snap_next = wrap ? digits : snap;
        ovf_next  = wrap ? overflow : snap_ovf;
        sel_digit = snap_next[idx_next];
    end

    bcd_to_seg7 u_dec (
        .bcd (sel_digit),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic blank;

    // A non-zero slot is blanked when it and every more-significant digit are zero
    always_comb begin
        blank = (idx_next != '0);
        for (int k = 1; k < N_DIGITS; k++) begin
            if ((k >= int'(idx_next)) && (snap_next[k] != '0)) begin
                blank = 1'b0;
            end
        end
    end
`endif

    // Prescaler, digit index and snapshot advance only on strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            idx      <= LAST;
            snap     <= '0;
            snap_ovf <= 1'b0;
        end else begin
            cnt      <= strobe ? '0 : cnt + 1'b1;
            idx      <= idx_next;
            snap     <= snap_next;
            snap_ovf <= ovf_next;
        end
    end

    // Registered display outputs; held blank from reset until the first strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode       <= '1;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (strobe) begin
`ifdef LEADING_ZERO_BLANK_EN
                if (blank) begin
                    anode <= '1;
                    seg   <= SEG_BLANK;
                end else begin
                    anode <= ~(N_DIGITS'(1) << idx_next);
                    seg   <= dec_seg;
                end
`else
                anode <= ~(N_DIGITS'(1) << idx_next);
                seg   <= dec_seg;
`endif
                dp <= ~((idx_next == '0) && ovf_next);
            end
        end
    end

endmodule

// File: tb/tb_seg7_display_mux.sv
// tb/tb_seg7_display_mux.sv - self-checking bench for seg7_display_mux
module tb_seg7_display_mux;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic [15:0] digits_bus;
    logic        overflow;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Model: edges since reset release, and the last captured frame
    int          edge_n;
    int          m_snap [N];
    logic        m_ovf;

    seg7_display_mux #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits_bus),
        .overflow    (overflow),
        .anode       (anode),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic int cur_slot();
        return (edge_n < DIV) ? -1 : ((edge_n / DIV) - 1) % N;
    endfunction

    task automatic model_reset();
        edge_n = 0;
        m_ovf  = 1'b0;
        for (int k = 0; k < N; k++) m_snap[k] = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e_anode;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fs;
        int         idx;
        int         value;
        int         pw;
        bit         blankd;
        idx = cur_slot();
        if (idx < 0) begin
            e_anode = 4'b1111;
            e_seg   = 7'b1111111;
            e_dp    = 1'b1;
            e_fs    = 1'b0;
        end else begin
            value = 0;
            pw    = 1;
            for (int k = 0; k < N; k++) begin
                value += m_snap[k] * pw;
                pw    *= 16;
            end
            blankd = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blankd = (idx > 0) && (value < (1 << (4 * idx)));
`endif
            e_anode = blankd ? 4'b1111 : ~(4'b0001 << idx);
            e_seg   = blankd ? 7'b1111111 : ref_seg(m_snap[idx]);
            e_dp    = !((idx == 0) && m_ovf);
            e_fs    = ((edge_n % DIV) == 0) && (idx == 0);
        end
        checks++;
        assert (anode === e_anode) else begin
            errors++;
            $error("FAIL %s anode edge=%0d obs=%b exp=%b", tag, edge_n, anode, e_anode);
        end
        checks++;
        assert (seg === e_seg) else begin
            errors++;
            $error("FAIL %s seg edge=%0d obs=%b exp=%b", tag, edge_n, seg, e_seg);
        end
        checks++;
        assert (dp === e_dp) else begin
            errors++;
            $error("FAIL %s dp edge=%0d obs=%b exp=%b", tag, edge_n, dp, e_dp);
        end
        checks++;
        assert (frame_start === e_fs) else begin
            errors++;
            $error("FAIL %s frame_start edge=%0d obs=%b exp=%b", tag, edge_n, frame_start, e_fs);
        end
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < N; k++) begin
            digits_bus[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
    endtask

    // One clock: advance the model at the edge, check at the falling edge,
    // then optionally perturb inputs (which may land on a wrap strobe)
    task automatic step(input string tag, input bit rnd);
        @(posedge clk);
        edge_n++;
        if (((edge_n % DIV) == 0) && (cur_slot() == 0)) begin
            for (int k = 0; k < N; k++) m_snap[k] = int'(digits_bus[4*k +: 4]);
            m_ovf = overflow;
        end
        @(negedge clk);
        check_outputs(tag);
        if (rnd) begin
            if ($urandom_range(0, 2) == 0) randomize_inputs();
            overflow = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int guard;
        rst        = 1'b0;
        digits_bus = 16'h1234;
        overflow   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < 24; i++) step("first_frame", 1'b0);

        guard = 0;
        while (cur_slot() != 1 && guard < 32) begin
            step("seek_d1", 1'b0);
            guard++;
        end
        checks++;
        assert (guard < 32) else begin
            errors++;
            $error("FAIL seek_d1 timeout obs=%0d exp=<32", guard);
        end
        digits_bus = 16'h9999;
        for (int i = 0; i < 24; i++) step("mid_frame", 1'b0);

        digits_bus = 16'h0007;
        for (int i = 0; i < 20; i++) step("leading_zero", 1'b0);

        digits_bus = 16'h000C;
        overflow   = 1'b1;
        for (int i = 0; i < 20; i++) step("overflow_dash", 1'b0);
        overflow = 1'b0;

        for (int i = 0; i < 6; i++) step("pre_async", 1'b0);
        #1 rst = 1'b0;
        model_reset();
        #1 check_outputs("async_reset");
        #2 rst = 1'b1;
        for (int i = 0; i < 20; i++) step("restart", 1'b0);

        for (int i = 0; i < 400; i++) step("random", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_display_mux.md
SEG7_DISPLAY_MUX -- requirements
Module: seg7_display_mux

Interface
REQ-001 Parameter N_DIGITS, default 4, is the number of multiplexed BCD digits (range 2..8).
REQ-002 Parameter REFRESH_DIV, default 50000, is the clk cycles per digit slot (range 2..2^20).
REQ-003 Port clk, in, 1, is the single system clock, with all logic on the rising edge.
REQ-004 Port rst, in, 1, is the asynchronous, active-low reset.
REQ-005 Port digits, in, N_DIGITS x BCDnumber_t, carries the BCD_counter digit values, index 0 = least significant.
REQ-006 Port overflow, in, 1, is the overflow flag from the counter chain.
REQ-007 Port anode, out, N_DIGITS, is the active-low digit enable, with at most one bit low.
REQ-008 Port seg, out, 7, is the active-low segments {g,f,e,d,c,b,a}.
REQ-009 Port dp, out, 1, is the active-low decimal point.
REQ-010 Port frame_start, out, 1, is a one-cycle pulse when a new snapshot is captured.

Function
REQ-011 The prescaler shall count 0..REFRESH_DIV-1 and wrap; the terminal-count cycle is the "strobe".
REQ-012 On each strobe, the digit index shall advance by 1, wrapping from N_DIGITS-1 to 0.
REQ-013 On a strobe where the index wraps to 0, the module shall capture digits and overflow into a snapshot register and pulse frame_start in the following cycle.
REQ-014 Display data shall come only from the snapshot, so input changes mid-frame shall not alter the current frame.
REQ-015 anode, seg and dp shall be registered and shall reflect the new index exactly one cycle after the strobe.
REQ-016 Decoding shall be 0..9 to standard 7-segment; codes 10..15 shall display '-' (seg = 7'b0111111).
REQ-017 dp shall be low only while digit 0 is selected and the snapshot overflow is 1.
REQ-018 Digit advance and snapshot capture shall never occur on non-strobe cycles.
REQ-019 A change in overflow on the same cycle as a wrap strobe shall be captured with the new value.

Reset
REQ-020 While rst is low, the module shall hold the prescaler at 0, the index at N_DIGITS-1, the snapshot at all-zero, anode all 1, seg all 1, dp 1 and frame_start 0.
REQ-021 Outputs shall stay blank after reset release until the first strobe, which shall select digit 0 and take the first snapshot.
REQ-022 Reset asserted mid-frame shall return the module to the REQ-020 state immediately, regardless of clk.

Configuration
REQ-023 With macro LEADING_ZERO_BLANK_EN defined, digit k>0 shall be blanked (anode stays high for its slot, seg all 1) when snapshot digits k..N_DIGITS-1 are all 0; digit 0 shall never be blanked.
REQ-024 With LEADING_ZERO_BLANK_EN undefined, all digits shall always be displayed and no blanking logic shall exist.

Structure
REQ-025 Package packs shall hold BCDnumber_t (existing), the 7-bit segment pattern typedef, and the constants SEG_BLANK and SEG_DASH.
REQ-026 Sub-module bcd_to_seg7 shall provide the purely combinational BCDnumber_t-to-segment decoder, instantiated once on the selected snapshot digit.

Verification (N_DIGITS=4, REFRESH_DIV=4)
REQ-027 Reset release, digits=4'h1,2,3,4 (d3..d0) -> anode 1110, seg=7'b0011001 (digit "4") starting 1 cycle after the first strobe (cycle 4), and frame_start pulses once.
REQ-028 Free run over 16 cycles -> anode sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110 with a new frame_start.
REQ-029 Change digits to 9,9,9,9 while digit 1 is displayed -> digits 2 and 3 still show the old values 2 and 1; the new values appear only after the next wrap.
REQ-030 digits=0,0,0,7 with LEADING_ZERO_BLANK_EN -> digits 3..1 are blank with anode all 1 in their slots; without the macro they show "0".
REQ-031 overflow=1 at the wrap strobe, digit d0=4'hC -> d0 slot shows seg=7'b0111111 with dp=0, and dp=1 in all other slots.
REQ-032 rst pulsed low for 3 ns mid-slot -> all outputs return to the reset values asynchronously, and the sequence restarts per REQ-021.
